// File: rtl/input_conditioner.sv
// Synchronizes and debounces a raw asynchronous input into a clean level with rise/fall pulses.
// Optional INPUT_CONDITIONER_EDGE_COUNT_EN adds an 8-bit wrapping rise counter output.
module input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 4
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic       raw_in,
    output logic       a,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy
`ifdef INPUT_CONDITIONER_EDGE_COUNT_EN
    ,
    output logic [7:0] edge_count
`endif
);

    typedef enum logic [1:0] {
        LOW_IDLE,
        WAIT_HIGH,
        HIGH_IDLE,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   a_d, rise_d, fall_d, busy_d;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= LOW_IDLE;
            cnt_q      <= '0;
            a          <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a          <= a_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LOW_IDLE: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = HIGH_IDLE;
                        cnt_d   = '0;
                        a_d     = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = LOW_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = HIGH_IDLE;
                    cnt_d   = '0;
                    a_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH_IDLE: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = LOW_IDLE;
                        cnt_d   = '0;
                        a_d     = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT_LOW;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = HIGH_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = LOW_IDLE;
                    cnt_d   = '0;
                    a_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOW_IDLE;
                cnt_d   = '0;
            end
        endcase
        // busy is registered from the next state so it tracks the qualifying states exactly
        busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    end

`ifdef INPUT_CONDITIONER_EDGE_COUNT_EN
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            edge_count <= '0;
        end else if (rise_d) begin
            edge_count <= edge_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: run-length debounce model compared every cycle,
// plus directed literal checks of latency, glitch rejection, bounce and reset abort.
module tb_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clock = 1'b0;
    logic nReset = 1'b1;
    logic raw_in = 1'b0;
    logic a, rise_pulse, fall_pulse, busy;
`ifdef INPUT_CONDITIONER_EDGE_COUNT_EN
    logic [7:0] edge_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    input_conditioner #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(4)
    ) dut (
        .clock(clock),
        .nReset(nReset),
        .raw_in(raw_in),
        .a(a),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy(busy)
`ifdef INPUT_CONDITIONER_EDGE_COUNT_EN
        ,
        .edge_count(edge_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: `a` flips once the synchronized input has disagreed with it for DEB consecutive samples.
    bit   hist[SYNC];
    bit   m_a, m_rise, m_fall, m_busy;
    int   m_run;
    logic [7:0] m_ec;

    initial begin
        m_a = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_run = 0; m_ec = '0;
        for (int i = 0; i < SYNC; i++) hist[i] = 0;
        forever begin
            @(posedge clock or negedge nReset);
            if (!nReset) begin
                m_a = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_run = 0; m_ec = '0;
                for (int i = 0; i < SYNC; i++) hist[i] = 0;
            end else begin
                bit sv;
                sv = hist[SYNC-1];
                for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = raw_in;
                m_rise = 0;
                m_fall = 0;
                if (sv != m_a) begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_a   = sv;
                        m_run = 0;
                        if (sv) begin
                            m_rise = 1;
                            m_ec   = m_ec + 8'd1;
                        end else begin
                            m_fall = 1;
                        end
                    end
                end else begin
                    m_run = 0;
                end
                m_busy = (m_run != 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            check("model_a", {7'd0, a}, {7'd0, m_a});
            check("model_rise", {7'd0, rise_pulse}, {7'd0, m_rise});
            check("model_fall", {7'd0, fall_pulse}, {7'd0, m_fall});
            check("model_busy", {7'd0, busy}, {7'd0, m_busy});
            check("pulse_excl", {7'd0, rise_pulse & fall_pulse}, 8'd0);
`ifdef INPUT_CONDITIONER_EDGE_COUNT_EN
            check("model_ec", edge_count, m_ec);
`endif
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clock);
        #1;
    endtask

    // Expected per-edge values (edges 1..7) after a clean level change with defaults
    logic [6:0] chg_new   = 7'b1100000;
    logic [6:0] pulse_pat = 7'b0100000;
    logic [6:0] busy_pat  = 7'b0011100;

    initial begin
        int rises;
        #1;
        nReset = 1'b0;
        raw_in = 1'b1;
        for (int c = 0; c < 2; c++) begin
            edge_wait();
            check("rst_a", {7'd0, a}, 8'd0);
            check("rst_rise", {7'd0, rise_pulse}, 8'd0);
            check("rst_fall", {7'd0, fall_pulse}, 8'd0);
            check("rst_busy", {7'd0, busy}, 8'd0);
        end
        step();
        nReset = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            edge_wait();
            if (e == 5) check("rst_rel_a5", {7'd0, a}, 8'd0);
            if (e == 6) check("rst_rel_a6", {7'd0, a}, 8'd1);
        end
        repeat (3) step();

        // clean fall
        raw_in = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            edge_wait();
            check("fall_a", {7'd0, a}, {7'd0, ~chg_new[e-1]});
            check("fall_pulse", {7'd0, fall_pulse}, {7'd0, pulse_pat[e-1]});
            check("fall_busy", {7'd0, busy}, {7'd0, busy_pat[e-1]});
        end
        repeat (3) step();

        // clean rise
        raw_in = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            edge_wait();
            check("rise_a", {7'd0, a}, {7'd0, chg_new[e-1]});
            check("rise_pulse", {7'd0, rise_pulse}, {7'd0, pulse_pat[e-1]});
            check("rise_busy", {7'd0, busy}, {7'd0, busy_pat[e-1]});
        end
        step();
        raw_in = 1'b0;
        repeat (10) step();

        // glitch of 3 cycles
        raw_in = 1'b1;
        repeat (3) step();
        raw_in = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            edge_wait();
            check("glitch_a", {7'd0, a}, 8'd0);
            check("glitch_pulses", {6'd0, rise_pulse, fall_pulse}, 8'd0);
        end
        check("glitch_busy_end", {7'd0, busy}, 8'd0);
        step();

        // bounce then settle
        raw_in = 1'b1; step();
        raw_in = 1'b0; step();
        raw_in = 1'b1; step();
        raw_in = 1'b0; step();
        raw_in = 1'b1;
        rises = 0;
        for (int e = 1; e <= 12; e++) begin
            edge_wait();
            if (rise_pulse) rises++;
            if (e == 5) check("bounce_a5", {7'd0, a}, 8'd0);
            if (e == 6) check("bounce_a6", {7'd0, a}, 8'd1);
        end
        check("bounce_rises", rises[7:0], 8'd1);
        step();

        // fall aborted by reset mid-qualification
        raw_in = 1'b0;
        for (int e = 1; e <= 4; e++) edge_wait();
        check("abort_busy", {7'd0, busy}, 8'd1);
        check("abort_a_pre", {7'd0, a}, 8'd1);
        nReset = 1'b0;
        #1;
        check("abort_a", {7'd0, a}, 8'd0);
        check("abort_busy_rst", {7'd0, busy}, 8'd0);
        step();
        nReset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            edge_wait();
            check("abort_no_fall", {7'd0, fall_pulse}, 8'd0);
            check("abort_a_low", {7'd0, a}, 8'd0);
        end
        step();

        // randomized phase, compared every cycle by the model
        for (int i = 0; i < 300; i++) begin
            int hold;
            hold   = int'($urandom_range(1, 8));
            raw_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) begin
                nReset = 1'b0;
                step();
                nReset = 1'b1;
            end
            repeat (hold) step();
        end

`ifdef INPUT_CONDITIONER_EDGE_COUNT_EN
        raw_in = 1'b0;
        nReset = 1'b0;
        step();
        nReset = 1'b1;
        step();
        for (int p = 0; p < 257; p++) begin
            raw_in = 1'b1;
            repeat (8) step();
            if (p == 256) check("edge_count_wrap", edge_count, 8'd1);
            raw_in = 1'b0;
            repeat (8) step();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream front-end for the single-bit FSM stages (circuit1/circuit2). It turns an asynchronous, possibly bouncing raw input into the clean, clock-aligned level `a` those stages consume.
- Synchronizes the raw input and debounces it with a consecutive-sample counter.
- Emits one-cycle rise/fall pulses alongside the clean level.
- Drops straight into the existing bench in place of the directly driven `a`.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive equal synchronized samples required to accept a new level; legal range 1..(2^CNT_W - 1).
- CNT_W, 4, debounce counter width.

Ports:
- clock  input  1  sole clock; all flops update on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- raw_in  input  1  raw asynchronous input level.
- a  output  1  debounced, synchronized level; feeds the downstream FSM `a` input.
- rise_pulse  output  1  high for exactly one cycle when `a` goes 0->1.
- fall_pulse  output  1  high for exactly one cycle when `a` goes 1->0.
- busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset:
  - nReset=0 asynchronously clears all sync flops, the counter, `a`, rise_pulse, fall_pulse and busy to 0.
  - FSM enters LOW_IDLE.
  - Reset asserted mid-qualification aborts it immediately; no pulse is emitted.
- Synchronizer:
  - Chain of SYNC_STAGES flops; the last stage is `s`.
  - The FSM only ever reads `s`, never raw_in.
- FSM states: LOW_IDLE, WAIT_HIGH, HIGH_IDLE, WAIT_LOW.
- LOW_IDLE:
  - s=0: stay.
  - s=1 and DEBOUNCE_CYCLES=1: commit high this edge.
  - s=1 otherwise: go to WAIT_HIGH, cnt=1.
- WAIT_HIGH:
  - s=0: back to LOW_IDLE, cnt=0; glitch rejected, no output change.
  - s=1 and cnt==DEBOUNCE_CYCLES-1: commit high.
  - Otherwise: cnt=cnt+1.
- Commit high:
  - a<=1, rise_pulse<=1, state HIGH_IDLE, cnt=0.
- HIGH_IDLE / WAIT_LOW: mirror images of the above, with s=0 as the candidate level.
- Commit low:
  - a<=0, fall_pulse<=1, state LOW_IDLE, cnt=0.
- Pulses:
  - Registered; deasserted on the edge after commit.
  - Each pulse coincides with the first cycle of the new `a` level.
  - rise_pulse and fall_pulse are never high simultaneously.
- busy: registered; equals 1 exactly when the state is WAIT_HIGH or WAIT_LOW.
- Latency:
  - Count edge 1 as the first rising edge that samples the new raw_in value into sync stage 1.
  - `a` changes on edge SYNC_STAGES+DEBOUNCE_CYCLES, provided raw_in stays stable throughout.
  - Defaults: `a` changes on edge 6.
- Glitch rejection: a pulse on `s` shorter than DEBOUNCE_CYCLES consecutive samples never changes `a`.
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1 and never wraps.
  - It is cleared on every state exit.
- Simultaneous events: a raw toggle on the same edge as a commit is simply sampled; the new state re-evaluates `s` on the following edge.

Optional Feature:
- Macro: INPUT_CONDITIONER_EDGE_COUNT_EN.
- Defined:
  - Adds output port edge_count [7:0].
  - edge_count increments by 1 on every cycle rise_pulse=1 and wraps 255->0.
  - It is cleared asynchronously by nReset=0 and is registered, so it updates on the same edge that raises rise_pulse.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold nReset=0 for 2 cycles with raw_in=1 -> a=0, rise_pulse=0, fall_pulse=0, busy=0 throughout; after release, a=1 on edge 6.
- Clean rise: defaults, raw_in 0->1 and held -> busy=1 from edge 3 through edge 5; a=1 and rise_pulse=1 at edge 6; rise_pulse=0 at edge 7; busy=0 at edge 6.
- Glitch: raw_in high for exactly 3 cycles, then low -> a stays 0, no pulses; busy returns to 0.
- Bounce then settle: raw_in toggles 1,0,1,0 on successive cycles, then is held 1 -> a rises exactly 6 edges after the final 0->1; exactly one rise_pulse.
- Fall, plus reset mid-qualification:
  - With a=1, drive raw_in=0 and held -> a=0 and fall_pulse=1 at edge 6.
  - Repeat, but pulse nReset=0 at edge 4 -> a=0 immediately, fall_pulse never asserted.
- With INPUT_CONDITIONER_EDGE_COUNT_EN: 257 qualified rise/fall pairs -> edge_count=1 after the last rise.
